// File: rtl/sar_search4.sv
// sar_search4: 4-bit successive-approximation search driven by an
// external magnitude comparator, MSB-first with early exit on equality.
module sar_search4 (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cmp_gt,
    input  logic       cmp_lt,
    input  logic       cmp_eq,
    output logic [3:0] trial,
    output logic       busy,
    output logic       done,
    output logic [3:0] result,
    output logic       found,
    output logic       error,
    output logic [2:0] steps
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TEST = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_n;
    logic [3:0] r_trial;
    logic [3:0] w_trial_n;
    logic [1:0] r_idx;
    logic [1:0] w_idx_n;
    logic [2:0] r_steps;
    logic [2:0] w_steps_n;
    logic [3:0] r_result;
    logic [3:0] w_result_n;
    logic       r_found;
    logic       w_found_n;
    logic       r_error;
    logic       w_error_n;

    logic       w_flags_ok;
    logic [1:0] w_idx_dec;
    logic [3:0] w_upd;

    assign w_flags_ok = (cmp_gt & ~cmp_lt & ~cmp_eq)
                      | (~cmp_gt & cmp_lt & ~cmp_eq)
                      | (~cmp_gt & ~cmp_lt & cmp_eq);
    assign w_idx_dec  = r_idx - 2'd1;

    // State and datapath registers; reset returns to an idle, all-zero block
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_trial  <= 4'd0;
            r_idx    <= 2'd0;
            r_steps  <= 3'd0;
            r_result <= 4'd0;
            r_found  <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_trial  <= w_trial_n;
            r_idx    <= w_idx_n;
            r_steps  <= w_steps_n;
            r_result <= w_result_n;
            r_found  <= w_found_n;
            r_error  <= w_error_n;
        end
    end

    // Next-state and search decisions; flag validity is checked before eq/gt/lt
    always_comb begin
        w_state_n  = r_state;
        w_trial_n  = r_trial;
        w_idx_n    = r_idx;
        w_steps_n  = r_steps;
        w_result_n = r_result;
        w_found_n  = r_found;
        w_error_n  = r_error;
        w_upd      = r_trial;
        w_upd[r_idx] = cmp_gt;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_trial_n = 4'b1000;
                    w_idx_n   = 2'd3;
                    w_steps_n = 3'd0;
                    w_found_n = 1'b0;
                    w_error_n = 1'b0;
                    w_state_n = S_TEST;
                end
            end
            S_TEST: begin
                w_steps_n = (r_steps == 3'd4) ? 3'd4 : r_steps + 3'd1;
                if (!w_flags_ok) begin
                    w_error_n  = 1'b1;
                    w_found_n  = 1'b0;
                    w_result_n = 4'd0;
                    w_state_n  = S_DONE;
                end else if (cmp_eq) begin
                    w_result_n = r_trial;
                    w_found_n  = 1'b1;
                    w_state_n  = S_DONE;
                end else if (r_idx != 2'd0) begin
                    w_trial_n            = w_upd;
                    w_trial_n[w_idx_dec] = 1'b1;
                    w_idx_n              = w_idx_dec;
                end else begin
                    w_trial_n  = w_upd;
                    w_result_n = w_upd;
                    w_found_n  = 1'b1;
                    w_state_n  = S_DONE;
                end
            end
            S_DONE: begin
                w_state_n = S_IDLE;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    assign trial  = r_trial;
    assign busy   = (r_state == S_TEST);
    assign done   = (r_state == S_DONE);
    assign result = r_result;
    assign found  = r_found;
    assign error  = r_error;
    assign steps  = r_steps;

endmodule

// File: tb/tb_sar_search4.sv
// tb_sar_search4: directed checks of sar_search4 against a behavioural
// comparator, with an override to inject inconsistent flags.
module tb_sar_search4;

    logic       clk;
    logic       rst;
    logic       start;
    logic       cmp_gt;
    logic       cmp_lt;
    logic       cmp_eq;
    logic [3:0] trial;
    logic       busy;
    logic       done;
    logic [3:0] result;
    logic       found;
    logic       error;
    logic [2:0] steps;

    logic [3:0] target;
    logic       frc;
    logic [2:0] frc_flags;

    int checks;
    int errors;

    sar_search4 dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .cmp_gt (cmp_gt),
        .cmp_lt (cmp_lt),
        .cmp_eq (cmp_eq),
        .trial  (trial),
        .busy   (busy),
        .done   (done),
        .result (result),
        .found  (found),
        .error  (error),
        .steps  (steps)
    );

    assign cmp_gt = frc ? frc_flags[2] : (target > trial);
    assign cmp_lt = frc ? frc_flags[1] : (target < trial);
    assign cmp_eq = frc ? frc_flags[0] : (target == trial);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_trial"}, {4'd0, trial}, 8'd0);
        chk({tag, "_result"}, {4'd0, result}, 8'd0);
        chk({tag, "_steps"}, {5'd0, steps}, 8'd0);
        chk({tag, "_busy"}, {7'd0, busy}, 8'd0);
        chk({tag, "_done"}, {7'd0, done}, 8'd0);
        chk({tag, "_found"}, {7'd0, found}, 8'd0);
        chk({tag, "_error"}, {7'd0, error}, 8'd0);
    endtask

    // One search: pulse start, watch 8 cycles, check trials, latency and results
    task automatic run_search(input string tag, input logic [3:0] tgt,
                              input logic [15:0] exp_tr, input int n_tr,
                              input logic mid_start,
                              input logic [3:0] e_res, input logic e_found,
                              input logic e_err, input logic [2:0] e_steps);
        int lat;
        int ndone;
        int nbusy;
        target = tgt;
        lat    = 0;
        ndone  = 0;
        nbusy  = 0;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (busy) begin
                if (nbusy < n_tr)
                    chk({tag, "_trial"}, {4'd0, trial},
                        {4'd0, exp_tr[15 - 4 * nbusy -: 4]});
                nbusy++;
            end
            if (done) begin
                ndone++;
                if (lat == 0) begin
                    lat = c;
                    chk({tag, "_result"}, {4'd0, result}, {4'd0, e_res});
                    chk({tag, "_found"}, {7'd0, found}, {7'd0, e_found});
                    chk({tag, "_error"}, {7'd0, error}, {7'd0, e_err});
                    chk({tag, "_steps"}, {5'd0, steps}, {5'd0, e_steps});
                    chk({tag, "_busy_in_done"}, {7'd0, busy}, 8'd0);
                end
            end
            start = (mid_start && c == 2) ? 1'b1 : 1'b0;
            tick();
        end
        start = 1'b0;
        chk({tag, "_latency"}, lat[7:0], {5'd0, e_steps} + 8'd1);
        chk({tag, "_done_count"}, ndone[7:0], 8'd1);
        chk({tag, "_busy_cycles"}, nbusy[7:0], {5'd0, e_steps});
        chk({tag, "_result_held"}, {4'd0, result}, {4'd0, e_res});
        chk({tag, "_found_held"}, {7'd0, found}, {7'd0, e_found});
        chk({tag, "_steps_held"}, {5'd0, steps}, {5'd0, e_steps});
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        target    = 4'd0;
        frc       = 1'b0;
        frc_flags = 3'b000;
        tick();
        tick();
        chk_idle_zero("reset");
        rst = 1'b0;
        tick();
        chk_idle_zero("idle_hold");

        run_search("t8", 4'd8, 16'h8000, 1, 1'b0, 4'd8, 1'b1, 1'b0, 3'd1);
        run_search("t11", 4'd11, 16'h8CAB, 4, 1'b0, 4'd11, 1'b1, 1'b0, 3'd4);
        run_search("t0", 4'd0, 16'h8421, 4, 1'b0, 4'd0, 1'b1, 1'b0, 3'd4);
        run_search("t15", 4'd15, 16'h8CEF, 4, 1'b1, 4'd15, 1'b1, 1'b0, 3'd4);

        frc       = 1'b1;
        frc_flags = 3'b110;
        run_search("bad", 4'd3, 16'h8000, 1, 1'b0, 4'd0, 1'b0, 1'b1, 3'd1);
        frc_flags = 3'b000;
        run_search("none", 4'd3, 16'h8000, 1, 1'b0, 4'd0, 1'b0, 1'b1, 3'd1);
        frc       = 1'b0;

        // Back-to-back: start in the cycle right after done is accepted
        target = 4'd6;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        for (int c = 0; c < 8 && !done; c++) tick();
        chk("b2b_first_done", {7'd0, done}, 8'd1);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b_accept_busy", {7'd0, busy}, 8'd1);
        chk("b2b_accept_trial", {4'd0, trial}, 8'h08);
        for (int c = 0; c < 8 && !done; c++) tick();
        chk("b2b_second_result", {4'd0, result}, 8'h06);
        tick();

        // Reset in the third TEST cycle
        target = 4'd9;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        tick();
        tick();
        chk("rst_mid_busy", {7'd0, busy}, 8'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle_zero("rst_mid");
        for (int c = 0; c < 5; c++) begin
            chk("rst_no_done", {7'd0, done}, 8'd0);
            tick();
        end
        run_search("t5", 4'd5, 16'h8465, 4, 1'b0, 4'd5, 1'b1, 1'b0, 3'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sar_search4.md
SAR_SEARCH4 -- requirements
Module: sar_search4

Interface
REQ-001 Parameters: none; datapath width is fixed at 4 bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request a new search; sampled only in IDLE.
REQ-005 cmp_gt  input  1  external comparator flag: target > trial.
REQ-006 cmp_lt  input  1  external comparator flag: target < trial.
REQ-007 cmp_eq  input  1  external comparator flag: target == trial.
REQ-008 trial  output  4  registered trial value driven to the external comparator B operand.
REQ-009 busy  output  1  high while the block is in TEST.
REQ-010 done  output  1  one-cycle pulse when a search ends.
REQ-011 result  output  4  search result; held from done until the next start.
REQ-012 found  output  1  result valid; held with result.
REQ-013 error  output  1  comparator flags were inconsistent; held with result.
REQ-014 steps  output  3  compare cycles used by the last search (1..4); held with result.

Function
REQ-015 The block SHALL act as the consuming end of a 4-bit magnitude comparator, successive-approximation searching MSB-first for the target value.
REQ-016 The external comparator is combinational; flags SHALL be sampled in the same cycle that trial is presented.
REQ-017 States SHALL be IDLE, TEST and DONE, with a 2-bit bit index idx and a steps counter.
REQ-018 IDLE with start=1 SHALL load trial=4'b1000, idx=3 and steps=0, clear found/error, and go to TEST.
REQ-019 IDLE with start=0 SHALL hold all outputs.
REQ-020 In TEST, steps SHALL increment by 1 every cycle.
REQ-021 In TEST, flag validity is defined as exactly one of cmp_gt, cmp_lt and cmp_eq high.
REQ-022 TEST with invalid flags SHALL set error=1, found=0 and result=0, then go to DONE.
REQ-023 TEST with cmp_eq=1 SHALL set result=trial and found=1, then go to DONE (early exit).
REQ-024 TEST with cmp_gt=1 SHALL keep trial[idx].
REQ-025 TEST with cmp_lt=1 SHALL clear trial[idx].
REQ-026 After a gt/lt decision with idx>0, the block SHALL set trial[idx-1]=1, decrement idx and stay in TEST.
REQ-027 After a gt/lt decision with idx==0, result SHALL equal the updated trial, found=1, and the state SHALL go to DONE.
REQ-028 DONE SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-029 busy=0 in DONE; result, found, error, steps and trial SHALL be held.
REQ-030 Latency: start accepted at cycle N; TEST occupies cycles N+1 to N+k (k=1..4); done pulses at N+k+1.
REQ-031 Maximum latency from start to done SHALL be 5 cycles.
REQ-032 start in TEST or DONE SHALL be ignored, not queued.
REQ-033 start in the cycle after done (IDLE) SHALL be accepted.
REQ-034 steps SHALL never exceed 4.
REQ-035 idx SHALL not wrap below 0.
REQ-036 Priority: the invalid-flag check SHALL precede the eq, gt and lt decisions.

Reset
REQ-037 rst=1 SHALL force IDLE on the next edge with trial=0, result=0, steps=0, busy=0, done=0, found=0 and error=0.
REQ-038 rst SHALL override start and any in-progress search, including mid-TEST.
REQ-039 A pending done pulse SHALL be cancelled by rst.
REQ-040 After rst deasserts, the first start SHALL begin a fresh search.

Verification
REQ-041 Target 8, start pulse -> trial 8 in cycle 1 with eq -> done in cycle 2, result=8, found=1, steps=1.
REQ-042 Target 11 -> trials 8(gt), 12(lt), 10(gt), 11(eq) -> result=11, found=1, steps=4, done 5 cycles after start.
REQ-043 Target 0 -> trials 8, 4, 2, 1 all lt -> result=0, found=1, error=0, steps=4.
REQ-044 Target 15 -> trials 8, 12, 14 (gt), then 15 (eq) -> result=15, steps=4; a start pulse during TEST is ignored (no restart, done only once).
REQ-045 cmp_gt=cmp_lt=1 at first TEST -> done in cycle 2, error=1, found=0, result=0, steps=1.
REQ-046 rst asserted in the 3rd TEST cycle -> next cycle IDLE, all outputs 0, no done pulse; a following start with target 5 -> result=5.
